scan_slot_sequencer: RTL and testbench

// - Registered slot sequencer driving the 3-bit select input of the 3-to-8 decoder.
// - Steps a slot index through the 8 decoder outputs:
//   - holds each slot for a programmable dwell time;
//   - skips slots disabled by a mask;
//   - runs in either direction.
// - Used for display-digit scanning, round-robin channel strobing and keypad column drive.

---
 rtl/scan_slot_sequencer_pkg.sv | 14 +
 rtl/scan_slot_sequencer_next_slot.sv | 35 +++
 rtl/scan_slot_sequencer.sv | 107 ++++++++++
 tb/tb_scan_slot_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_slot_sequencer_pkg.sv
// Shared constants and types for the scan slot sequencer.
// Slot count, select width, FSM states and direction encodings.
package scan_pkg;
  localparam int SLOTS = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/scan_slot_sequencer_next_slot.sv
// Combinational next-slot finder: first set mask bit strictly after cur,
// circular in the requested direction.
module scan_next_slot
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [SLOTS-1:0] mask,
  input  logic             dir,
  output logic [SEL_W-1:0] nxt,
  output logic             wrapped,
  output logic             any
);

  logic [SLOTS-1:0] rot;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] ofs;

  always_comb begin
    rot = '0;
    idx = '0;
    ofs = '0;
    // rot[i] is the slot i+1 steps away from cur in the scan direction
    for (int i = 0; i < SLOTS; i++) begin
      idx    = (dir == DIR_UP) ? cur + SEL_W'(i + 1) : cur - SEL_W'(i + 1);
      rot[i] = mask[idx];
    end
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (rot[i]) ofs = SEL_W'(i);
    end
    nxt     = (dir == DIR_UP) ? cur + ofs + SEL_W'(1) : cur - ofs - SEL_W'(1);
    wrapped = (dir == DIR_UP) ? (nxt <= cur) : (nxt >= cur);
    any     = |mask;
  end

endmodule

// File: rtl/scan_slot_sequencer.sv
// Slot sequencer: steps a registered 3-bit decoder select through enabled
// slots, holding each for dwell+1 cycles, in either direction.
//
// state | meaning
// IDLE  | not scanning; sel frozen, sel_valid low
// SCAN  | sel is an active slot; dwell counter running
module scan_slot_sequencer
  import scan_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SLOTS-1:0]   mask,
  input  logic               dir,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               step,
  output logic               wrap
);

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               valid_q, valid_d;
  logic               step_q, step_d;
  logic               wrap_q, wrap_d;

  logic [SEL_W-1:0]   cur_in;
  logic [SEL_W-1:0]   nxt;
  logic               wrapped;
  logic               any;

  // From IDLE, start one slot "before" the range so the finder yields the entry slot
  assign cur_in = (state_q == IDLE) ? ((dir == DIR_UP) ? SEL_W'(SLOTS - 1) : '0)
                                    : sel_q;

  scan_next_slot u_next (
    .cur     (cur_in),
    .mask    (mask),
    .dir     (dir),
    .nxt     (nxt),
    .wrapped (wrapped),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && any) begin
          state_d = SCAN;
          sel_d   = nxt;
          cnt_d   = dwell;
          valid_d = 1'b1;
          step_d  = 1'b1;
        end
      end
      SCAN: begin
        if (!en || !any) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d   = cnt_q - DWELL_W'(1);
          valid_d = 1'b1;
        end else begin
          sel_d   = nxt;
          cnt_d   = dwell;
          valid_d = 1'b1;
          step_d  = 1'b1;
          wrap_d  = wrapped;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sel       = sel_q;
  assign sel_valid = valid_q;
  assign step      = step_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_scan_slot_sequencer.sv
// Self-checking bench for scan_slot_sequencer against a list-based slot model.
module tb_scan_slot_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic       dir;
  logic [2:0] sel;
  logic       sel_valid;
  logic       step;
  logic       wrap;

  int checks;
  int failures;

  // reference model state
  int m_sel;
  bit m_run;
  bit m_step;
  bit m_wrap;
  int m_left;

  scan_slot_sequencer #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dwell     (dwell),
    .mask      (mask),
    .dir       (dir),
    .sel       (sel),
    .sel_valid (sel_valid),
    .step      (step),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enabled slots as a sorted list; pick next in scan order, wrapping to the far end.
  function automatic void next_of(input int cur, input logic [7:0] mk, input bit d,
                                  output int nx, output bit wr);
    int q[$];
    for (int k = 0; k < 8; k++) if (mk[k]) q.push_back(k);
    nx = -1;
    wr = 1'b0;
    if (!d) begin
      foreach (q[k]) if (nx < 0 && q[k] > cur) nx = q[k];
      if (nx < 0) begin nx = q[0]; wr = 1'b1; end
    end else begin
      for (int k = q.size() - 1; k >= 0; k--) if (nx < 0 && q[k] < cur) nx = q[k];
      if (nx < 0) begin nx = q[q.size() - 1]; wr = 1'b1; end
    end
  endfunction

  function automatic int entry_of(input logic [7:0] mk, input bit d);
    int lo, hi;
    lo = -1; hi = -1;
    for (int k = 0; k < 8; k++) if (mk[k]) begin
      if (lo < 0) lo = k;
      hi = k;
    end
    return d ? hi : lo;
  endfunction

  task automatic cycle();
    int nx;
    bit wr;
    @(posedge clk);
    if (rst) begin
      m_sel = 0; m_run = 0; m_step = 0; m_wrap = 0; m_left = 0;
    end else if (!m_run) begin
      m_step = 0; m_wrap = 0;
      if (en && mask != 0) begin
        m_run = 1; m_sel = entry_of(mask, dir); m_left = dwell; m_step = 1;
      end
    end else if (!en || mask == 0) begin
      m_run = 0; m_step = 0; m_wrap = 0;
    end else if (m_left > 0) begin
      m_left--; m_step = 0; m_wrap = 0;
    end else begin
      next_of(m_sel, mask, dir, nx, wr);
      m_sel = nx; m_left = dwell; m_step = 1; m_wrap = wr;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; mask = 8'hFF; dwell = 8'd2; dir = 0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if ({sel, sel_valid, step, wrap} !== 6'b0) begin
        failures++;
        $display("FAIL reset c%0d got sel=%0d v=%0b s=%0b w=%0b want all 0",
                 i, sel, sel_valid, step, wrap);
      end
    end
    en = 0; rst = 0;
    cycle();
    checks++;
    if ({sel, sel_valid, step, wrap} !== 6'b0) begin
      failures++;
      $display("FAIL reset_release got sel=%0d v=%0b s=%0b w=%0b want all 0",
               sel, sel_valid, step, wrap);
    end
  endtask

  task automatic test_full_up();
    int steps, wraps;
    steps = 0; wraps = 0;
    mask = 8'hFF; dwell = 8'd2; dir = 0; en = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      steps += step;
      wraps += wrap;
      checks++;
      if ({sel, sel_valid, step, wrap} !== {3'(m_sel), m_run, m_step, m_wrap}) begin
        failures++;
        $display("FAIL full_up c%0d got sel=%0d v=%0b s=%0b w=%0b want sel=%0d v=%0b s=%0b w=%0b",
                 i, sel, sel_valid, step, wrap, m_sel, m_run, m_step, m_wrap);
      end
      if (wrap) begin
        checks++;
        if (sel !== 3'd0) begin
          failures++;
          $display("FAIL full_up_wrap_sel got %0d want 0", sel);
        end
      end
    end
    checks++;
    if (steps != 10 || wraps != 1) begin
      failures++;
      $display("FAIL full_up_counts got steps=%0d wraps=%0d want 10 1", steps, wraps);
    end
  endtask

  task automatic test_skip_down();
    en = 0;
    cycle();
    mask = 8'b1010_0101; dwell = 8'd0; dir = 1; en = 1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if ({sel, sel_valid, step, wrap} !== {3'(m_sel), m_run, m_step, m_wrap}) begin
        failures++;
        $display("FAIL skip_down c%0d got sel=%0d v=%0b s=%0b w=%0b want sel=%0d v=%0b s=%0b w=%0b",
                 i, sel, sel_valid, step, wrap, m_sel, m_run, m_step, m_wrap);
      end
      if (i == 0) begin
        checks++;
        if (sel !== 3'd7) begin
          failures++;
          $display("FAIL skip_down_entry got %0d want 7", sel);
        end
      end
    end
  endtask

  task automatic test_single_slot();
    en = 0;
    cycle();
    mask = 8'h10; dwell = 8'd1; dir = 0; en = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if ({sel, sel_valid, step, wrap} !== {3'(m_sel), m_run, m_step, m_wrap}) begin
        failures++;
        $display("FAIL single c%0d got sel=%0d v=%0b s=%0b w=%0b want sel=%0d v=%0b s=%0b w=%0b",
                 i, sel, sel_valid, step, wrap, m_sel, m_run, m_step, m_wrap);
      end
      checks++;
      if (sel !== 3'd4 || (i > 0 && wrap !== step)) begin
        failures++;
        $display("FAIL single_fixed c%0d got sel=%0d s=%0b w=%0b want sel=4 w==s", i, sel, step, wrap);
      end
    end
  endtask

  task automatic test_stop_restart();
    int budget;
    en = 0;
    cycle();
    mask = 8'hFF; dwell = 8'd2; dir = 0; en = 1;
    budget = 0;
    do begin cycle(); budget++; end while (!(m_sel == 3 && m_left == 1) && budget < 100);
    checks++;
    if (budget >= 100) begin
      failures++;
      $display("FAIL stop_reach timeout got sel=%0d want 3", sel);
    end
    en = 0;
    cycle();
    checks++;
    if (sel_valid !== 1'b0 || sel !== 3'd3 || step !== 1'b0) begin
      failures++;
      $display("FAIL stop got sel=%0d v=%0b s=%0b want sel=3 v=0 s=0", sel, sel_valid, step);
    end
    en = 1;
    cycle();
    checks++;
    if (sel !== 3'd0 || step !== 1'b1 || sel_valid !== 1'b1) begin
      failures++;
      $display("FAIL restart got sel=%0d v=%0b s=%0b want sel=0 v=1 s=1", sel, sel_valid, step);
    end
    mask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (sel_valid !== 1'b0 || step !== 1'b0) begin
        failures++;
        $display("FAIL mask_zero c%0d got v=%0b s=%0b want 0 0", i, sel_valid, step);
      end
    end
  endtask

  task automatic test_midop();
    int budget;
    en = 0; mask = 8'hFF;
    cycle();
    dwell = 8'd3; dir = 0; en = 1;
    budget = 0;
    do begin cycle(); budget++; end while (!(m_sel == 2 && m_left == 2) && budget < 100);
    checks++;
    if (budget >= 100) begin
      failures++;
      $display("FAIL midop_reach timeout got sel=%0d want 2", sel);
    end
    mask = 8'hFB;
    for (int i = 0; i < 40; i++) begin
      cycle();
      checks++;
      if ({sel, sel_valid, step, wrap} !== {3'(m_sel), m_run, m_step, m_wrap}) begin
        failures++;
        $display("FAIL midop c%0d got sel=%0d v=%0b s=%0b w=%0b want sel=%0d v=%0b s=%0b w=%0b",
                 i, sel, sel_valid, step, wrap, m_sel, m_run, m_step, m_wrap);
      end
      if (i >= 3) begin
        checks++;
        if (sel === 3'd2) begin
          failures++;
          $display("FAIL midop_skip c%0d got sel=2 want not 2", i);
        end
      end
    end
    rst = 1;
    cycle();
    rst = 0;
    checks++;
    if ({sel, sel_valid, step, wrap} !== 6'b0) begin
      failures++;
      $display("FAIL midop_reset got sel=%0d v=%0b s=%0b w=%0b want all 0",
               sel, sel_valid, step, wrap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      en  = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 99) < 10) mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 99) < 15) dir = 1'($urandom);
      if ($urandom_range(0, 99) < 10) dwell = 8'($urandom_range(0, 3));
      cycle();
      checks++;
      if ({sel, sel_valid, step, wrap} !== {3'(m_sel), m_run, m_step, m_wrap}) begin
        failures++;
        $display("FAIL random c%0d got sel=%0d v=%0b s=%0b w=%0b want sel=%0d v=%0b s=%0b w=%0b",
                 i, sel, sel_valid, step, wrap, m_sel, m_run, m_step, m_wrap);
      end
    end
    rst = 0;
  endtask

  initial begin
    checks = 0; failures = 0;
    m_sel = 0; m_run = 0; m_step = 0; m_wrap = 0; m_left = 0;
    rst = 1; en = 0; dwell = '0; mask = '0; dir = 0;
    test_reset();
    test_full_up();
    test_skip_down();
    test_single_slot();
    test_stop_restart();
    test_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
